// File: rtl/imm_ext_pipe_if.sv
// rtl/imm_ext_pipe_if.sv - input/output handshake bundle for the pipelined immediate extender
interface imm_ext_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [2:0]       ImmSrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  ImmExt;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  // Upstream decode / downstream execute side, as seen by whoever drives the block
  modport master (
    output in_valid, instruction, ImmSrc, in_tag, out_ready,
    input  in_ready, out_valid, ImmExt, out_tag, out_err
  );

  // The extender itself
  modport slave (
    input  in_valid, instruction, ImmSrc, in_tag, out_ready,
    output in_ready, out_valid, ImmExt, out_tag, out_err
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - immediate extension with 2-entry output FIFO; optional macro IMM_AUTODECODE_EN
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  imm_ext_pipe_if.slave bus
);
  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_U     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_NONE  = 3'd5;
  localparam logic [2:0] FMT_Z     = 3'd6;
  localparam logic [2:0] FMT_SHAMT = 3'd7;

  logic [2:0]       fmt;
  logic             decodeErr;
  logic [31:0]      imm32;
  logic             signExt;
  logic [XLEN-1:0]  immNext;
  logic             errNext;

  logic [XLEN-1:0]  immMem [2];
  logic [TAG_W-1:0] tagMem [2];
  logic             errMem [2];
  logic             rdPtr;
  logic             wrPtr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

`ifdef IMM_AUTODECODE_EN
  // Derive the immediate format from the opcode; unknown opcodes are flagged
  always_comb begin
    fmt       = FMT_NONE;
    decodeErr = 1'b0;
    case (bus.instruction[6:0])
      7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0010011: fmt = (bus.instruction[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
      7'b0100011: fmt = FMT_S;
      7'b1100011: fmt = FMT_B;
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111: fmt = FMT_J;
      7'b1110011: fmt = bus.instruction[14] ? FMT_Z : FMT_I;
      7'b0110011: fmt = FMT_NONE;
      default: begin
        fmt       = FMT_NONE;
        decodeErr = 1'b1;
      end
    endcase
  end
`else
  // Format comes straight from the decoder's select
  always_comb begin
    fmt       = bus.ImmSrc;
    decodeErr = 1'b0;
  end
`endif

  // Build a 32-bit immediate, then sign- or zero-extend to XLEN
  always_comb begin
    imm32   = '0;
    signExt = 1'b0;
    case (fmt)
      FMT_I: begin
        imm32   = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
        signExt = 1'b1;
      end
      FMT_S: begin
        imm32   = {{20{bus.instruction[31]}}, bus.instruction[31:25], bus.instruction[11:7]};
        signExt = 1'b1;
      end
      FMT_B: begin
        imm32   = {{19{bus.instruction[31]}}, bus.instruction[31], bus.instruction[7],
                   bus.instruction[30:25], bus.instruction[11:8], 1'b0};
        signExt = 1'b1;
      end
      FMT_U: begin
        imm32   = {bus.instruction[31:12], 12'b0};
        signExt = 1'b1;
      end
      FMT_J: begin
        imm32   = {{11{bus.instruction[31]}}, bus.instruction[31], bus.instruction[19:12],
                   bus.instruction[20], bus.instruction[30:21], 1'b0};
        signExt = 1'b1;
      end
      FMT_Z:     imm32 = {27'b0, bus.instruction[19:15]};
      FMT_SHAMT: imm32 = (XLEN == 64) ? {26'b0, bus.instruction[25:20]}
                                      : {27'b0, bus.instruction[24:20]};
      default:   imm32 = '0;
    endcase
    immNext = signExt ? XLEN'($signed(imm32)) : XLEN'(imm32);
    // A 6-bit shift amount is illegal on a 32-bit datapath
    errNext = decodeErr | ((fmt == FMT_SHAMT) && (XLEN == 32) && bus.instruction[25]);
  end

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        immMem[i] <= '0;
        tagMem[i] <= '0;
        errMem[i] <= 1'b0;
      end
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        immMem[wrPtr] <= immNext;
        tagMem[wrPtr] <= bus.in_tag;
        errMem[wrPtr] <= errNext;
        wrPtr         <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Head-of-queue outputs, forced to zero while empty
  always_comb begin
    bus.in_ready  = (count != 2'd2);
    bus.out_valid = (count != 2'd0);
    bus.ImmExt    = bus.out_valid ? immMem[rdPtr] : '0;
    bus.out_tag   = bus.out_valid ? tagMem[rdPtr] : '0;
    bus.out_err   = bus.out_valid ? errMem[rdPtr] : 1'b0;
  end
endmodule
